// File: rtl/hdmi_fifo_fill_ctrl.sv
// HDMI pixel fetch controller: issues raster-order pixel requests in bursts,
// captures the returned pixel one cycle later into a 2-entry output buffer and
// presents it on a valid/ready stream tagged with start-of-frame / end-of-line.
module hdmi_fifo_fill_ctrl #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned BURST = 64
) (
  input  logic        rstn,
  input  logic        clk,
  input  logic        en,
  input  logic        w_half_empty,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] pix_rgb,
  input  logic        fifo_tready,
  output logic        fifo_tvalid,
  output logic [25:0] fifo_tdata,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] X_LAST   = 12'(H_ACT - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_ACT - 1);
  localparam logic [12:0] BURST_LD = 13'(BURST);

  typedef enum logic {S_WAIT, S_BURST} state_t;

  state_t      state, state_nxt;
  logic [12:0] burst_cnt;
  logic        req_d;
  logic        sof_d;
  logic        eol_d;
  logic [25:0] buf_mem [0:1];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic        push;
  logic        pop;
  logic [2:0]  pending;
  logic        credit;

  assign push        = req_d;
  assign pop         = fifo_tvalid & fifo_tready;
  assign fifo_tvalid = (occ != 2'd0);
  assign fifo_tdata  = fifo_tvalid ? buf_mem[rd_ptr] : '0;

  // Slots committed after this cycle's handshake: buffered entries minus the
  // one leaving now, plus the pixel landing now. A new request needs a free slot.
  assign pending = {1'b0, occ} - {2'b0, pop} + {2'b0, req_d};
  assign credit  = (pending < 3'd2);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_WAIT;
    else       state <= state_nxt;
  end

  // Next-state and request strobe
  always_comb begin
    state_nxt = state;
    pix_req   = 1'b0;
    case (state)
      S_WAIT: begin
        if (en && w_half_empty) state_nxt = S_BURST;
      end
      S_BURST: begin
        if (credit) begin
          pix_req = 1'b1;
          if (burst_cnt == 13'd1) state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Burst counter: loaded on burst start, one count per request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                    burst_cnt <= '0;
    else if (state == S_WAIT && state_nxt == S_BURST) burst_cnt <= BURST_LD;
    else if (pix_req)                             burst_cnt <= burst_cnt - 13'd1;
  end

  // Raster position of the next pixel to request, plus frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_x     <= '0;
      pix_y     <= '0;
      frame_cnt <= '0;
    end else if (pix_req) begin
      if (pix_x == X_LAST) begin
        pix_x <= '0;
        if (pix_y == Y_LAST) begin
          pix_y     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          pix_y <= pix_y + 12'd1;
        end
      end else begin
        pix_x <= pix_x + 12'd1;
      end
    end
  end

  // In-flight request and its frame markers, aligned with the returning pix_rgb
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_d <= 1'b0;
      sof_d <= 1'b0;
      eol_d <= 1'b0;
    end else begin
      req_d <= pix_req;
      sof_d <= pix_req && (pix_x == '0) && (pix_y == '0);
      eol_d <= pix_req && (pix_x == X_LAST);
    end
  end

  // Two-entry output buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 2; i++) buf_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= {eol_d, sof_d, pix_rgb};
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_hdmi_fifo_fill_ctrl.sv
// Directed bench for hdmi_fifo_fill_ctrl at 4x2 pixels, burst of 3.
module tb_hdmi_fifo_fill_ctrl;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned B = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        w_half_empty = 1'b0;
  logic        fifo_tready = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        fifo_tvalid;
  logic [25:0] fifo_tdata;
  logic [15:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the stream
  logic [11:0] ex = '0;
  logic [11:0] ey = '0;
  logic [15:0] ef = '0;
  logic [25:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [25:0] prev_data = '0;

  // Pixel source: returns {y, x} of the request one cycle later, garbage otherwise
  logic        cap_req = 1'b0;
  logic [23:0] cap_dat = '0;

  always #5 clk = ~clk;

  hdmi_fifo_fill_ctrl #(.H_ACT(H), .V_ACT(V), .BURST(B)) dut (
    .rstn         (rstn),
    .clk          (clk),
    .en           (en),
    .w_half_empty (w_half_empty),
    .pix_req      (pix_req),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .fifo_tready  (fifo_tready),
    .fifo_tvalid  (fifo_tvalid),
    .fifo_tdata   (fifo_tdata),
    .frame_cnt    (frame_cnt)
  );

  always @(negedge clk) begin
    #2;
    cap_req = pix_req;
    cap_dat = {pix_y, pix_x};
  end

  always @(posedge clk) begin
    #1;
    pix_rgb = cap_req ? cap_dat : 24'hBADBAD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then check the stream
  task automatic cyc(input logic rdy, input logic hemp, input logic e);
    @(negedge clk);
    fifo_tready  = rdy;
    w_half_empty = hemp;
    en           = e;
    #1;
    chk("pix_x", {20'd0, pix_x}, {20'd0, ex});
    chk("pix_y", {20'd0, pix_y}, {20'd0, ey});
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, ef});
    chk("occupancy_le_2", {31'd0, exp_q.size() <= 2}, 32'd1);
    if (prev_stall) begin
      chk("stall_valid", {31'd0, fifo_tvalid}, 32'd1);
      chk("stall_data", {6'd0, fifo_tdata}, {6'd0, prev_data});
    end
    if (fifo_tvalid && fifo_tready) begin
      chk("pop_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("tdata", {6'd0, fifo_tdata}, {6'd0, exp_q[0]});
        exp_q.delete(0);
      end
    end
    if (pix_req) begin
      exp_q.push_back({ex == 12'(H - 1), (ex == 12'd0) && (ey == 12'd0), ey, ex});
      if (ex == 12'(H - 1)) begin
        ex = '0;
        if (ey == 12'(V - 1)) begin
          ey = '0;
          ef = ef + 16'd1;
        end else begin
          ey = ey + 12'd1;
        end
      end else begin
        ex = ex + 12'd1;
      end
    end
    prev_stall = fifo_tvalid && !fifo_tready;
    prev_data  = fifo_tdata;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pix_req", {31'd0, pix_req}, 32'd0);
    chk("rst_pix_x", {20'd0, pix_x}, 32'd0);
    chk("rst_pix_y", {20'd0, pix_y}, 32'd0);
    chk("rst_tvalid", {31'd0, fifo_tvalid}, 32'd0);
    chk("rst_tdata", {6'd0, fifo_tdata}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
  endtask

  initial begin
    logic [11:0] req_pat;
    int          n_req;
    logic        found;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // Burst pattern: 3 requests, one WAIT cycle, repeat; frame wraps after (3,1)
    req_pat = 12'b1110_1110_1110;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("burst_pattern_req", {31'd0, pix_req}, {31'd0, req_pat[i]});
      if (i == 3)  chk("sof_first_pixel", {6'd0, fifo_tdata}, 32'h0100_0000);
      if (i == 6)  chk("gap_no_valid", {31'd0, fifo_tvalid}, 32'd0);
      if (i == 7)  chk("eol_pixel_3_0", {6'd0, fifo_tdata}, 32'h0200_0003);
      if (i == 10) chk("frame_before_wrap", {16'd0, frame_cnt}, 32'd0);
      if (i == 11) begin
        chk("frame_after_wrap", {16'd0, frame_cnt}, 32'd1);
        chk("wrap_x", {20'd0, pix_x}, 32'd0);
        chk("wrap_y", {20'd0, pix_y}, 32'd0);
      end
    end
    repeat (6) cyc(1'b1, 1'b1, 1'b1);

    // Backpressure for 10 cycles, then release
    repeat (10) cyc(1'b0, 1'b1, 1'b1);
    chk("bp_req_stalled", {31'd0, pix_req}, 32'd0);
    chk("bp_valid_held", {31'd0, fifo_tvalid}, 32'd1);
    repeat (20) cyc(1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    chk("drain_empty_model", exp_q.size(), 32'd0);
    chk("drain_empty_dut", {31'd0, fifo_tvalid}, 32'd0);

    // Throttle: no bursts without w_half_empty
    n_req = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      n_req += int'(pix_req);
    end
    chk("throttle_no_req", n_req, 32'd0);

    // en drops right after burst start: burst still completes, none follows
    cyc(1'b1, 1'b1, 1'b1);
    chk("start_wait_req", {31'd0, pix_req}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("burst_first_req", {31'd0, pix_req}, 32'd1);
    n_req = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      n_req += int'(pix_req);
    end
    chk("en_low_burst_len", n_req, B);

    // Random ready / fill level with scoreboard checks every cycle
    for (int i = 0; i < 4000; i++) begin
      cyc(1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)), 1'b1);
    end
    repeat (15) cyc(1'b1, 1'b1, 1'b0);
    chk("rand_drain_model", exp_q.size(), 32'd0);
    chk("rand_drain_dut", {31'd0, fifo_tvalid}, 32'd0);

    // Reset mid-burst with the buffer full
    repeat (8) cyc(1'b0, 1'b1, 1'b1);
    chk("pre_reset_valid", {31'd0, fifo_tvalid}, 32'd1);
    @(negedge clk);
    en   = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    ex = '0;
    ey = '0;
    ef = '0;
    prev_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    chk("post_reset_wait", {31'd0, pix_req}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("post_reset_first_req", {31'd0, pix_req}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!found) begin
        cyc(1'b1, 1'b1, 1'b1);
        if (fifo_tvalid) begin
          found = 1'b1;
          chk("post_reset_first_tdata", {6'd0, fifo_tdata}, 32'h0100_0000);
        end
      end
    end
    chk("post_reset_valid_seen", {31'd0, found}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
